exec_seq: RTL
=============

EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 Parameter ALU_LAT, 1, ALU result latency in cycles (legal range 1..15).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port start  input  1  request to execute one instruction; sampled only when busy=0.
REQ-005 Port icode, ifun  input  4 each  instruction code and function.
REQ-006 Port valA, valB, valC  input  64 each  operand values.
REQ-007 Port control  output  2  ALU op select: 00 add, 01 sub (a-b), 10 xor, 11 and.
REQ-008 Port a, b  output  64 each  registered ALU operands.
REQ-009 Port ans  input  64  ALU result, valid ALU_LAT cycles after a/b/control are stable.
REQ-010 Port busy  output  1  high while an instruction is in flight.
REQ-011 Port done  output  1  one-cycle pulse; valE/cnd/err are valid in the same cycle.
REQ-012 Port valE  output  64  registered execute result.
REQ-013 Port cnd  output  1  registered condition result.
REQ-014 Port cc  output  3  condition codes {zf,sf,of}.
REQ-015 Port err  output  1  invalid-instruction flag; valid with done.

Function
REQ-016 FSM states: IDLE, EXEC, DONE; busy SHALL equal (state==EXEC).
REQ-017 Start accepted in IDLE or DONE: capture icode/ifun, load a/b/control, clear wait counter, go EXEC; without start, DONE goes to IDLE.
REQ-018 EXEC SHALL last exactly ALU_LAT cycles; at the last EXEC edge, register valE=ans, cnd, err, cc update; go DONE.
REQ-019 done SHALL be high exactly in DONE, i.e. ALU_LAT edges after the accepting edge; back-to-back start in DONE gives one instruction per ALU_LAT+1 cycles.
REQ-020 start while busy=1 SHALL be ignored; a, b, control SHALL stay stable throughout EXEC.
REQ-021 Operand mapping: 0/1 halt/nop a=0 b=0; 2 rrmov/cmov a=valA b=0; 3 irmov a=0 b=valC; 4/5 rmmov/mrmov a=valB b=valC; 8 call, A push a=valB b=-8; 9 ret, B pop a=valA b=8; 7 jxx a=0 b=0; all these control=00.
REQ-022 OPq (6): ifun 0 add a=valA b=valB; 1 sub a=valB b=valA control=01 (valB-valA); 2 and control=11; 3 xor control=10.
REQ-023 Only OPq SHALL update cc: zf=(ans==0); sf=ans[63]; of for add = a,b same sign and ans sign differs from a; for sub = a,b signs differ and ans sign differs from a; of=0 for and/xor.
REQ-024 cnd for icode 2/7 from cc at acceptance, ifun 0..6: always, le (sf^of)|zf, l sf^of, e zf, ne ~zf, ge ~(sf^of), g ~(sf^of)&~zf; cnd=0 for all other icodes.
REQ-025 Invalid (icode>B, OPq ifun>3, icode 2/7 ifun>6): err=1, valE=0, cnd=0, cc unchanged, same latency.
REQ-026 Arithmetic is 64-bit two's complement, wrap-around; no carry out.

Reset
REQ-027 rst high SHALL immediately force IDLE, busy=0, done=0, valE=0, cnd=0, err=0, a=b=0, control=00, cc={1,0,0}.
REQ-028 Reset mid-EXEC SHALL abort the instruction with no done pulse and no cc update; first start after rst release behaves as from power-up.

Structure
REQ-029 Shared package SHALL hold icode constants (HALT..POPQ), ifun condition constants, ALU control encodings and the FSM state enum.
REQ-030 One sub-module cond_eval (combinational cc+ifun -> cnd) SHALL be reused for cmov and jxx; the ALU stays external.

Verification
REQ-031 OPq add valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, ALU_LAT=1 -> a/b driven, done 1 edge after accept, valE=0x8000_0000_0000_0000, cc={0,1,1}.
REQ-032 OPq sub valA=5, valB=5 then jxx ifun 3 (je) back-to-back in DONE -> first valE=0, cc={1,0,0}; second cnd=1, valE=0, cc unchanged.
REQ-033 push valB=0x100, ALU_LAT=3 -> busy high 3 cycles, start pulses during busy ignored, done with valE=0xF8, cnd=0.
REQ-034 icode=0xC, then OPq ifun=7 -> each gives err=1, valE=0, cnd=0, cc retained from prior value.
REQ-035 rst asserted mid-EXEC of OPq xor valA=valB=0xFF -> no done, cc={1,0,0}, all outputs zero immediately, next irmov valC=42 returns valE=42.
REQ-036 After OPq sub valA=3, valB=1 (valE=-2), cmov ifun 1..6 -> cnd=1,1,0,1,0,0 respectively.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// Shared definitions for the execute-stage sequencer: instruction codes,
// condition functions, ALU control encodings and the sequencer state type.
package exec_seq_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  // {zf,sf,of}
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  function automatic logic instr_valid(input logic [3:0] ic, input logic [3:0] fn);
    logic v;
    if (ic == I_OPQ)                         v = (fn <= F_XOR);
    else if (ic == I_RRMOVQ || ic == I_JXX)  v = (fn <= C_G);
    else                                     v = (ic <= I_POPQ);
    return v;
  endfunction

endpackage

// File: rtl/exec_seq_cond_eval.sv
// Combinational branch/move condition evaluation from {zf,sf,of} and ifun.
module cond_eval
  import exec_seq_pkg::*;
(
  input  logic [2:0] i_cc,
  input  logic [3:0] i_ifun,
  output logic       o_cnd
);

  logic w_zf, w_sf, w_of, w_lt;

  assign w_zf = i_cc[2];
  assign w_sf = i_cc[1];
  assign w_of = i_cc[0];
  assign w_lt = w_sf ^ w_of;

  always_comb begin
    o_cnd = 1'b0;
    case (i_ifun)
      C_YES:   o_cnd = 1'b1;
      C_LE:    o_cnd = w_lt | w_zf;
      C_L:     o_cnd = w_lt;
      C_E:     o_cnd = w_zf;
      C_NE:    o_cnd = ~w_zf;
      C_GE:    o_cnd = ~w_lt;
      C_G:     o_cnd = ~w_lt & ~w_zf;
      default: o_cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_seq.sv
// Execute-stage sequencer: loads operands for an external ALU, waits ALU_LAT
// cycles, then registers the result, condition flag, codes and error flag.
module exec_seq
  import exec_seq_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [1:0]  control,
  output logic [63:0] a,
  output logic [63:0] b,
  input  logic [63:0] ans,
  output logic        busy,
  output logic        done,
  output logic [63:0] valE,
  output logic        cnd,
  output logic [2:0]  cc,
  output logic        err
);

  localparam logic [3:0] LAST = 4'(ALU_LAT - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_icode, r_ifun, r_cnt;
  logic [63:0] r_a, r_b, r_valE;
  logic [1:0]  r_ctl;
  logic        r_cnd, r_err;
  logic [2:0]  r_cc;

  logic [63:0] w_a, w_b;
  logic [1:0]  w_ctl;
  logic        w_accept, w_finish, w_valid, w_cond, w_of, w_use_cond;

  // Operand selection from the incoming instruction
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_ctl = ALU_ADD;
    case (icode)
      I_HALT, I_NOP, I_JXX: ;
      I_RRMOVQ:             w_a = valA;
      I_IRMOVQ:             w_b = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        w_a = valB;
        w_b = valC;
      end
      I_CALL, I_PUSHQ: begin
        w_a = valB;
        w_b = 64'hFFFF_FFFF_FFFF_FFF8;
      end
      I_RET, I_POPQ: begin
        w_a = valA;
        w_b = 64'd8;
      end
      I_OPQ: begin
        case (ifun)
          F_ADD: begin w_a = valA; w_b = valB; w_ctl = ALU_ADD; end
          F_SUB: begin w_a = valB; w_b = valA; w_ctl = ALU_SUB; end
          F_AND: begin w_a = valA; w_b = valB; w_ctl = ALU_AND; end
          F_XOR: begin w_a = valA; w_b = valB; w_ctl = ALU_XOR; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_EXEC;
          w_accept = 1'b1;
        end
      end
      S_EXEC: begin
        if (r_cnt == LAST) begin
          w_next   = S_DONE;
          w_finish = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          w_next   = S_EXEC;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  cond_eval u_cond_eval (
    .i_cc   (r_cc),
    .i_ifun (r_ifun),
    .o_cnd  (w_cond)
  );

  assign w_valid    = instr_valid(r_icode, r_ifun);
  assign w_use_cond = (r_icode == I_RRMOVQ) || (r_icode == I_JXX);

  always_comb begin
    w_of = 1'b0;
    case (r_ctl)
      ALU_ADD: w_of = (r_a[63] == r_b[63]) && (ans[63] != r_a[63]);
      ALU_SUB: w_of = (r_a[63] != r_b[63]) && (ans[63] != r_a[63]);
      default: w_of = 1'b0;
    endcase
  end

  // cc is only written at the end of EXEC, so evaluating the condition from
  // r_cc at completion equals evaluating it at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_icode <= '0;
      r_ifun  <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ctl   <= ALU_ADD;
      r_valE  <= '0;
      r_cnd   <= 1'b0;
      r_err   <= 1'b0;
      r_cc    <= CC_RESET;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_icode <= icode;
        r_ifun  <= ifun;
        r_a     <= w_a;
        r_b     <= w_b;
        r_ctl   <= w_ctl;
        r_cnt   <= '0;
      end else if (r_state == S_EXEC && !w_finish) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_finish) begin
        if (!w_valid) begin
          r_valE <= '0;
          r_cnd  <= 1'b0;
          r_err  <= 1'b1;
        end else begin
          r_valE <= ans;
          r_cnd  <= w_use_cond & w_cond;
          r_err  <= 1'b0;
          if (r_icode == I_OPQ) r_cc <= {(ans == '0), ans[63], w_of};
        end
      end
    end
  end

  assign busy    = (r_state == S_EXEC);
  assign done    = (r_state == S_DONE);
  assign control = r_ctl;
  assign a       = r_a;
  assign b       = r_b;
  assign valE    = r_valE;
  assign cnd     = r_cnd;
  assign cc      = r_cc;
  assign err     = r_err;

endmodule
